// File: rtl/subtractor_serial_8bit.sv
// subtractor_serial_8bit: bit-serial (LSB-first) subtractor computing a - b - bin with borrow-out and zero flag
module subtractor_serial_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, diff_q, diff_d;
  logic brw_q, brw_d, bout_q, bout_d, zero_q, zero_d;
  logic d, brw_n;
  logic [WIDTH-1:0] r_n;
  assign d     = a_q[0] ^ b_q[0] ^ brw_q;
  assign brw_n = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
  assign r_n   = {d, r_q[WIDTH-1:1]};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    r_d     = r_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    if (state_q == IDLE && start) begin
      a_d     = a;
      b_d     = b;
      brw_d   = bin;
      cnt_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      brw_d = brw_n;
      r_d   = r_n;
      cnt_d = cnt_q + 1'b1;
      // Result registers change only here, so partial sums never reach diff.
      if (cnt_q == LAST) begin
        state_d = DONE;
        diff_d  = r_n;
        bout_d  = brw_n;
        zero_d  = ~|r_n;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      r_q     <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      r_q     <= r_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
    end
  end
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_subtractor_serial_8bit.sv
// tb_subtractor_serial_8bit: directed and random checks of the serial subtractor against an arithmetic model
module tb_subtractor_serial_8bit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic bin = 1'b0;
  logic busy, done, bout, zero;
  logic [7:0] diff;
  int n_chk = 0, n_fail = 0;
  subtractor_serial_8bit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .zero(zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  // Full transaction; inj >= 0 issues a competing start on that RUN cycle.
  task automatic op(input logic [7:0] a_v, input logic [7:0] b_v, input logic bin_v, input int inj);
    int r, k, bc;
    logic [7:0] ed;
    r  = int'(a_v) - int'(b_v) - int'(bin_v);
    ed = r[7:0];
    @(negedge clk);
    a = a_v; b = b_v; bin = bin_v; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    k = 0; bc = 0;
    while (k < 20) begin
      @(negedge clk);
      if (done) break;
      if (busy) bc++;
      start = (k == inj);
      if (start) begin a = 8'h00; b = 8'h01; bin = 1'b0; end
      else begin a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom); end
      k++;
    end
    start = 1'b0;
    check("latency", k, 8);
    check("busy_cycles", bc, 8);
    check("busy_at_done", busy, 0);
    check("diff", diff, ed);
    check("bout", bout, r < 0);
    check("zero", zero, ed == 8'h00);
    @(negedge clk);
    check("done_single", done, 0);
  endtask
  initial begin
    int dn;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_zero", zero, 0);
    #12 rst = 1'b0;
    op(8'h00, 8'h01, 1'b0, -1);
    op(8'hFF, 8'h0F, 1'b0, -1);
    op(8'h10, 8'h0F, 1'b1, -1);
    op(8'h00, 8'hFF, 1'b1, -1);
    op(8'h05, 8'h03, 1'b0, 3);
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check("ignored_start", dn, 0);
    // Held start: DONE -> IDLE, then accepted on the first IDLE edge.
    @(negedge clk);
    a = 8'h03; b = 8'h01; bin = 1'b0; start = 1'b1;
    dn = 0;
    while (!done && dn < 20) begin @(negedge clk); dn++; end
    check("held_reach_done", done, 1);
    @(negedge clk);
    check("held_idle_busy", busy, 0);
    check("held_idle_done", done, 0);
    @(negedge clk);
    check("held_accept", busy, 1);
    start = 1'b0;
    dn = 0;
    while (!done && dn < 20) begin @(negedge clk); dn++; end
    check("held_diff", diff, 8'h02);
    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_diff", diff, 0);
    check("arst_bout", bout, 0);
    #1 rst = 1'b0;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("arst_no_done", dn, 0);
    op(8'h09, 8'h04, 1'b0, -1);
    for (int i = 0; i < 1000; i++)
      op(8'($urandom), 8'($urandom), 1'($urandom), -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
